// File: rtl/mem_responder.sv
//==============================================================================
// Module      : mem_responder
// Description : Byte-addressed little-endian RAM that answers datapath memory
//               requests with a Ready pulse and optional read wait states.
//               Optional macro MEM_ALIGN_CHECK_EN rejects unaligned accesses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic        Ready,
    output logic [31:0] Dataout,
    output logic        Fault
);

    localparam int              c_DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_DEPTH - 4);
    localparam logic [2:0]      c_WAIT_M1 = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAITS = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ok;
    logic [2:0]        r_cnt;
    logic [31:0]       r_dout;
    logic [7:0]        r_mem [0:c_DEPTH-1];

    logic              w_accept;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_rd_ok;
    logic [31:0]       w_rd_word;
    logic              w_rd_load;

    assign w_accept = (r_state == c_IDLE) && Req;

    // No wrap-around: the top three byte addresses cannot start a word.
`ifdef MEM_ALIGN_CHECK_EN
    assign w_in_range = (Address[31:ADDR_W] == '0) && (Address[ADDR_W-1:0] <= c_LAST)
                        && (Address[1:0] == 2'b00);
`else
    assign w_in_range = (Address[31:ADDR_W] == '0) && (Address[ADDR_W-1:0] <= c_LAST);
`endif

    // With WAIT=0 the read samples RAM on the accept edge itself, so the
    // live address is used there; otherwise the latched copy.
    assign w_rd_idx  = (r_state == c_IDLE) ? Address[ADDR_W-1:0] : r_addr;
    assign w_rd_ok   = (r_state == c_IDLE) ? w_in_range : r_ok;
    assign w_rd_word = {r_mem[w_rd_idx + ADDR_W'(3)], r_mem[w_rd_idx + ADDR_W'(2)],
                        r_mem[w_rd_idx + ADDR_W'(1)], r_mem[w_rd_idx]};
    assign w_rd_load = (w_accept && !Wr && (WAIT == 0))
                       || ((r_state == c_WAITS) && (r_cnt == 3'd0));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
            r_ok    <= 1'b0;
            r_cnt   <= 3'd0;
            r_dout  <= 32'd0;
        end else begin
            if (w_rd_load) begin
                r_dout <= w_rd_ok ? w_rd_word : 32'd0;
            end
            case (r_state)
                c_IDLE: begin
                    if (Req) begin
                        r_addr <= Address[ADDR_W-1:0];
                        r_ok   <= w_in_range;
                        if (Wr || (WAIT == 0)) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAITS;
                            r_cnt   <= c_WAIT_M1;
                        end
                    end
                end
                c_WAITS: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // RAM is never cleared; a write coinciding with Reset is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset && w_accept && Wr && w_in_range) begin
            r_mem[Address[ADDR_W-1:0]]               <= Datain[7:0];
            r_mem[Address[ADDR_W-1:0] + ADDR_W'(1)]  <= Datain[15:8];
            r_mem[Address[ADDR_W-1:0] + ADDR_W'(2)]  <= Datain[23:16];
            r_mem[Address[ADDR_W-1:0] + ADDR_W'(3)]  <= Datain[31:24];
        end
    end

    assign Ready   = (r_state == c_RESP);
    assign Fault   = Ready && !r_ok;
    assign Dataout = r_dout;

endmodule

`default_nettype wire
